// File: rtl/div_alu_pkg.sv
// Shared definitions for the execute-stage MUL/DIV units: default width,
// control FSM encoding and go/done handshake polarity.
package div_alu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  localparam logic HS_GO_ACTIVE   = 1'b1;
  localparam logic HS_DONE_ACTIVE = 1'b1;

endpackage

// File: rtl/div_alu_control_unit.sv
// Control FSM for the restoring divider (IDLE/DIV/DONE), split out the same
// way as the multiplier's control unit.
module div_control_unit
  import div_alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic dbz,
  input  logic z,
  output logic initialize,
  output logic step,
  output logic finish,
  output logic busy,
  output logic done
);

  div_state_e r_state;
  div_state_e w_state_nxt;
  logic       w_go;

  assign w_go = (go == HS_GO_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_state_nxt = dbz ? ST_DONE : ST_DIV;
      ST_DIV:  if (z)    w_state_nxt = ST_DONE;
      ST_DONE:           w_state_nxt = ST_IDLE;
      default:           w_state_nxt = ST_IDLE;
    endcase
  end

  // initialize fires on every accepted go; the datapath uses dbz to pick
  // between starting the iteration and loading the divide-by-zero result.
  always_comb begin
    initialize = (r_state == ST_IDLE) && w_go;
    step       = (r_state == ST_DIV);
    finish     = (r_state == ST_DIV) && z;
    busy       = (r_state == ST_DIV);
    done       = (r_state == ST_DONE) ? HS_DONE_ACTIVE : ~HS_DONE_ACTIVE;
  end

endmodule

// File: rtl/div_alu.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient
// bit per clock, sharing the multiplier's go/done handshake.
module div_alu
  import div_alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] x, input logic en);
    return (en && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  logic [WIDTH-1:0] r_r, r_q, r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg, r_r_neg;
  logic [WIDTH-1:0] r_quotient, r_remainder;
  logic             r_dbz;

  logic             w_init, w_step, w_finish, w_dbz, w_z;
  logic [WIDTH:0]   w_r_sh;
  logic [WIDTH+1:0] w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_r_nxt, w_q_nxt;

  assign w_dbz = (divisor == '0);
  assign w_z   = (r_cnt == '0);

  div_control_unit u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .dbz        (w_dbz),
    .z          (w_z),
    .initialize (w_init),
    .step       (w_step),
    .finish     (w_finish),
    .busy       (busy),
    .done       (done)
  );

  // Shifted partial remainder can reach 2*D-1, so the trial needs a guard bit
  // beyond WIDTH+1 to keep its sign unambiguous.
  assign w_r_sh  = {r_r, r_q[WIDTH-1]};
  assign w_trial = {1'b0, w_r_sh} - {2'b00, r_d};
  assign w_ge    = ~w_trial[WIDTH+1];
  assign w_r_nxt = w_ge ? w_trial[WIDTH-1:0] : w_r_sh[WIDTH-1:0];
  assign w_q_nxt = {r_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (w_init) begin
      r_d     <= abs_if(divisor, signed_op);
      r_q     <= abs_if(dividend, signed_op);
      r_r     <= '0;
      r_q_neg <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_r_neg <= signed_op & dividend[WIDTH-1];
    end else if (w_step) begin
      r_r <= w_r_nxt;
      r_q <= w_q_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      if (w_init)      r_cnt <= CNT_W'(WIDTH - 1);
      else if (w_step) r_cnt <= r_cnt - 1'b1;

      if (w_init && w_dbz) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
        r_dbz       <= 1'b1;
      end else if (w_finish) begin
        r_quotient  <= neg_if(w_q_nxt, r_q_neg);
        r_remainder <= neg_if(w_r_nxt, r_r_neg);
        r_dbz       <= 1'b0;
      end
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_alu.sv
// Directed bench for div_alu: table of divides plus reset-abort and
// held-go sequences.
module tb_div_alu;

  logic        clk = 1'b0;
  logic        rst, go, signed_op, busy, done, div_by_zero;
  logic [31:0] dividend, divisor, quotient, remainder;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc_ctr = 0;

  typedef struct {
    logic        so;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    string       nm;
  } vec_t;

  vec_t vecs[13];

  div_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ctr++;
  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic garbage();
    signed_op = 1'($urandom_range(0, 1));
    dividend  = $urandom;
    divisor   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
  endtask

  task automatic run_op(input vec_t v);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    go = 1'b1; signed_op = v.so; dividend = v.a; divisor = v.b;
    @(negedge clk);
    go = 1'b0; garbage();
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({v.nm, " latency"}, cyc, v.dbz ? 32'd1 : 32'd33);
    check({v.nm, " busy_cycles"}, busy_cnt, v.dbz ? 32'd0 : 32'd32);
    check({v.nm, " quotient"}, quotient, v.q);
    check({v.nm, " remainder"}, remainder, v.r);
    check({v.nm, " dbz"}, div_by_zero, v.dbz);
    @(negedge clk);
    check({v.nm, " done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int n;
    int base;
    int t_prev;
    vec_t hv[3];

    vecs[0]  = '{1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          1'b0, "u100/7"};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002,   32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, "s-7/2"};
    vecs[2]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE,   32'hFFFFFFFD,   32'h00000001,   1'b0, "s7/-2"};
    vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'h00000000,   1'b0, "s_ovf"};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001,   32'hFFFFFFFF,   32'h00000000,   1'b0, "u_max/1"};
    vecs[5]  = '{1'b0, 32'd5,        32'd9,          32'd0,          32'd5,          1'b0, "u5/9"};
    vecs[6]  = '{1'b0, 32'd1234,     32'd0,          32'hFFFFFFFF,   32'd1234,       1'b1, "u_dbz"};
    vecs[7]  = '{1'b1, 32'd1234,     32'd0,          32'hFFFFFFFF,   32'd1234,       1'b1, "s_dbz"};
    vecs[8]  = '{1'b0, 32'd10,       32'd3,          32'd3,          32'd1,          1'b0, "u10/3"};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, "s-100/7"};
    vecs[10] = '{1'b1, 32'd100,      32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, "s100/-7"};
    vecs[11] = '{1'b0, 32'h80000000, 32'd3,          32'h2AAAAAAA,   32'd2,          1'b0, "u2^31/3"};
    vecs[12] = '{1'b1, 32'h80000000, 32'd1,          32'h80000000,   32'd0,          1'b0, "s_min/1"};

    rst = 1'b1; go = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst quotient", quotient, 32'd0);
    check("rst remainder", remainder, 32'd0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst dbz", div_by_zero, 1'b0);

    for (int i = 0; i < 13; i++) run_op(vecs[i]);

    // Reset in cycle 10 of a divide abandons it without a done pulse.
    @(negedge clk);
    go = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    go = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort quotient", quotient, 32'd0);
    check("abort remainder", remainder, 32'd0);
    check("abort dbz", div_by_zero, 1'b0);
    base = done_cnt;
    repeat (40) @(negedge clk);
    check("abort no_done", done_cnt - base, 32'd0);
    run_op('{1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, "post_rst20/6"});

    // go held high: operands only sampled in IDLE, one done per accept.
    hv[0] = '{1'b0, 32'd100,      32'd7,  32'd14,       32'd2,        1'b0, "held0"};
    hv[1] = '{1'b1, 32'hFFFFFF9C, 32'd7,  32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, "held1"};
    hv[2] = '{1'b0, 32'd1000,     32'd10, 32'd100,      32'd0,        1'b0, "held2"};
    base = done_cnt;
    t_prev = 0;
    @(negedge clk);
    go = 1'b1; signed_op = hv[0].so; dividend = hv[0].a; divisor = hv[0].b;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      garbage();
      n = 0;
      while (!done && n < 40) begin
        @(negedge clk);
        garbage();
        n++;
      end
      check({hv[k].nm, " timeout"}, (n < 40) ? 32'd1 : 32'd0, 32'd1);
      check({hv[k].nm, " quotient"}, quotient, hv[k].q);
      check({hv[k].nm, " remainder"}, remainder, hv[k].r);
      if (k > 0) check({hv[k].nm, " period"}, cyc_ctr - t_prev, 32'd34);
      t_prev = cyc_ctr;
      if (k < 2) begin
        signed_op = hv[k+1].so; dividend = hv[k+1].a; divisor = hv[k+1].b;
      end else begin
        go = 1'b0;
      end
      @(negedge clk);
    end
    go = 1'b0;
    repeat (40) @(negedge clk);
    check("held done_count", done_cnt - base, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
